// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid words (ID, timestamp)
// and reports match, mismatch or timeout against build-time constants.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXP_ID        = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP = 32'd1523548286,
  parameter bit          USE_RDV       = 1'b0,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_DAT_ID,
    S_REQ_TS,
    S_DAT_TS,
    S_FIN
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic        expired;
  logic        go;
  logic        cap_id;
  logic        cap_ts;
  logic        fin;
  logic        abort;

  // Abort on the last allowed cycle so the strobe is up TIMEOUT_CYC cycles.
  assign expired = (cnt_q == TO_LAST);

  assign avm_read = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          go      = 1'b1;
          state_d = S_REQ_ID;
        end
      end
      (state_q == S_REQ_ID): begin
        if (!avm_waitrequest) begin
          if (USE_RDV) begin
            state_d = S_DAT_ID;
          end else begin
            cap_id  = 1'b1;
            state_d = S_REQ_TS;
          end
        end else if (expired) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      (state_q == S_DAT_ID): begin
        if (avm_readdatavalid) begin
          cap_id  = 1'b1;
          state_d = S_REQ_TS;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      (state_q == S_REQ_TS): begin
        if (!avm_waitrequest) begin
          if (USE_RDV) begin
            state_d = S_DAT_TS;
          end else begin
            cap_ts  = 1'b1;
            state_d = S_FIN;
          end
        end else if (expired) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      (state_q == S_DAT_TS): begin
        if (avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = S_FIN;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      (state_q == S_FIN): begin
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Address is only refreshed when a request phase is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_address <= 1'b0;
    end else if (state_d != state_q) begin
      if (state_d == S_REQ_ID) begin
        avm_address <= 1'b0;
      end else if (state_d == S_REQ_TS) begin
        avm_address <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value <= '0;
      ts_value <= '0;
    end else if (go) begin
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else if (go) begin
      done    <= 1'b0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else if (fin) begin
      done    <= 1'b1;
      id_ok   <= (id_value == EXP_ID);
      ts_ok   <= (ts_value == EXP_TIMESTAMP);
    end else if (abort) begin
      done    <= 1'b1;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench: instance A (accept-cycle data) and B (readdatavalid)
// against small slave models, with hand-computed timing and results.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS   = 32'd1523548286;
  localparam logic [31:0] B_ID = 32'h1234_5678;

  logic clock = 1'b0;
  logic reset;
  logic start;

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // instance A
  logic        a_addr, a_read, a_wr, a_busy, a_done;
  logic        a_id_ok, a_ts_ok, a_to;
  logic        a_rdv = 1'b0;
  logic [31:0] a_rd, a_idv, a_tsv;
  logic [31:0] id_ret = 32'd0;
  logic [31:0] ts_ret = TS;
  logic        stuck = 1'b0;
  int          stall_cfg = 0;
  int          wcnt = 0;

  assign a_wr = a_read && (stuck || (wcnt < stall_cfg));
  assign a_rd = a_addr ? ts_ret : id_ret;

  always @(posedge clock) begin
    if (a_read && a_wr) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  nios_system_sysid_checker #(
    .EXP_ID(32'd0), .EXP_TIMESTAMP(TS),
    .USE_RDV(1'b0), .TIMEOUT_CYC(8)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(a_wr), .avm_readdata(a_rd),
    .avm_readdatavalid(a_rdv),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok),
    .ts_ok(a_ts_ok), .timeout(a_to),
    .id_value(a_idv), .ts_value(a_tsv)
  );

  // instance B: data strobe two cycles after accept
  logic        b_addr, b_read, b_busy, b_done;
  logic        b_id_ok, b_ts_ok, b_to, b_rdv;
  logic        b_wr = 1'b0;
  logic [31:0] b_rd, b_idv, b_tsv;
  logic        p1 = 1'b0, p2 = 1'b0, lat = 1'b0;
  logic        stray = 1'b0;

  assign b_rdv = p2 | stray;
  assign b_rd  = lat ? TS : B_ID;

  always @(posedge clock) begin
    p1 <= b_read;
    p2 <= p1;
    if (b_read) lat <= b_addr;
  end

  nios_system_sysid_checker #(
    .EXP_ID(B_ID), .EXP_TIMESTAMP(TS),
    .USE_RDV(1'b1), .TIMEOUT_CYC(8)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(b_wr), .avm_readdata(b_rd),
    .avm_readdatavalid(b_rdv),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok),
    .ts_ok(b_ts_ok), .timeout(b_to),
    .id_value(b_idv), .ts_value(b_tsv)
  );

  // Pulses start (cycle 0) and measures; no comparisons here.
  task automatic run(output int a_cyc, output int b_cyc,
                     output int nread, output int addr_err);
    int   acc;
    logic exp_addr;
    a_cyc = 0; b_cyc = 0; nread = 0; addr_err = 0; acc = 0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (a_read) begin
        nread++;
        exp_addr = (acc != 0);
        if (a_addr !== exp_addr) addr_err++;
        if (!a_wr) acc++;
      end
      if (a_done && a_cyc == 0) a_cyc = n;
      if (b_done && b_cyc == 0) b_cyc = n;
      if (a_cyc != 0 && b_cyc != 0) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    #12;
    checks++;
    if ({a_busy, a_done, a_read, a_addr, a_id_ok, a_ts_ok, a_to} !== 7'b0) begin
      failures++; $display("FAIL reset_a_flags got=%b exp=0",
        {a_busy, a_done, a_read, a_addr, a_id_ok, a_ts_ok, a_to});
    end
    checks++;
    if ({a_idv, a_tsv} !== 64'd0) begin
      failures++; $display("FAIL reset_a_values got=%h exp=0", {a_idv, a_tsv});
    end
    checks++;
    if ({b_busy, b_done, b_read, b_id_ok, b_ts_ok, b_to} !== 6'b0) begin
      failures++; $display("FAIL reset_b_flags got=%b exp=0",
        {b_busy, b_done, b_read, b_id_ok, b_ts_ok, b_to});
    end
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=0", a_busy);
    end
  endtask

  task automatic test_rdv;
    int ac, bc, nr, ae;
    @(negedge clock); stray = 1'b1;
    @(negedge clock); stray = 1'b0;
    @(negedge clock);
    checks++;
    if ({b_busy, b_done, b_idv} !== 34'd0) begin
      failures++; $display("FAIL rdv_stray got=%h exp=0", {b_busy, b_done, b_idv});
    end
    run(ac, bc, nr, ae);
    checks++;
    if (bc !== 8) begin
      failures++; $display("FAIL rdv_done_cycle got=%0d exp=8", bc);
    end
    checks++;
    if (b_idv !== B_ID || b_tsv !== TS) begin
      failures++; $display("FAIL rdv_values got=%h/%h exp=%h/%h", b_idv, b_tsv, B_ID, TS);
    end
    checks++;
    if ({b_id_ok, b_ts_ok, b_to} !== 3'b110) begin
      failures++; $display("FAIL rdv_flags got=%b exp=110", {b_id_ok, b_ts_ok, b_to});
    end
  endtask

  task automatic test_match;
    int ac, bc, nr, ae;
    run(ac, bc, nr, ae);
    checks++;
    if (ac !== 4) begin
      failures++; $display("FAIL match_done_cycle got=%0d exp=4", ac);
    end
    checks++;
    if (nr !== 2 || ae !== 0) begin
      failures++; $display("FAIL match_reads got=%0d/%0d exp=2/0", nr, ae);
    end
    checks++;
    if ({a_id_ok, a_ts_ok, a_to} !== 3'b110) begin
      failures++; $display("FAIL match_flags got=%b exp=110", {a_id_ok, a_ts_ok, a_to});
    end
    checks++;
    if (a_idv !== 32'd0 || a_tsv !== TS) begin
      failures++; $display("FAIL match_values got=%h/%h exp=0/%h", a_idv, a_tsv, TS);
    end
  endtask

  task automatic test_ts_mismatch;
    int ac, bc, nr, ae;
    ts_ret = 32'h5ACF_0000;
    run(ac, bc, nr, ae);
    checks++;
    if ({a_done, a_id_ok, a_ts_ok} !== 3'b110) begin
      failures++; $display("FAIL mism_flags got=%b exp=110", {a_done, a_id_ok, a_ts_ok});
    end
    checks++;
    if (a_tsv !== 32'h5ACF_0000) begin
      failures++; $display("FAIL mism_ts_value got=%h exp=5acf0000", a_tsv);
    end
    ts_ret = TS;
  endtask

  task automatic test_stall;
    int ac, bc, nr, ae;
    stall_cfg = 3;
    run(ac, bc, nr, ae);
    checks++;
    if (ac !== 10) begin
      failures++; $display("FAIL stall_done_cycle got=%0d exp=10", ac);
    end
    checks++;
    if (nr !== 8 || ae !== 0) begin
      failures++; $display("FAIL stall_reads got=%0d/%0d exp=8/0", nr, ae);
    end
    checks++;
    if ({a_id_ok, a_ts_ok} !== 2'b11) begin
      failures++; $display("FAIL stall_flags got=%b exp=11", {a_id_ok, a_ts_ok});
    end
    stall_cfg = 0;
  endtask

  task automatic test_timeout;
    int ac, bc, nr, ae;
    stuck = 1'b1;
    run(ac, bc, nr, ae);
    checks++;
    if (ac !== 9 || nr !== 8) begin
      failures++; $display("FAIL to_timing got=%0d/%0d exp=9/8", ac, nr);
    end
    checks++;
    if ({a_to, a_id_ok, a_ts_ok, a_busy, a_read} !== 5'b10000) begin
      failures++; $display("FAIL to_flags got=%b exp=10000",
        {a_to, a_id_ok, a_ts_ok, a_busy, a_read});
    end
    stuck = 1'b0;
    run(ac, bc, nr, ae);
    checks++;
    if (ac !== 4 || {a_to, a_id_ok, a_ts_ok} !== 3'b011) begin
      failures++; $display("FAIL to_rerun got=%0d/%b exp=4/011", ac, {a_to, a_id_ok, a_ts_ok});
    end
  endtask

  task automatic test_start_ignored;
    int busy_after = 0;
    int done_at4 = 0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (n == 4) done_at4 = int'(a_done);
      if (n >= 5 && (a_busy || a_read)) busy_after++;
      start = (n == 2 || n == 3);
    end
    start = 1'b0;
    checks++;
    if (done_at4 !== 1) begin
      failures++; $display("FAIL busy_start_done got=%0d exp=1", done_at4);
    end
    checks++;
    if (busy_after !== 0 || a_done !== 1'b1) begin
      failures++; $display("FAIL busy_start_queued got=%0d/%b exp=0/1", busy_after, a_done);
    end
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_b got=%b/%b exp=1/0", b_done, b_busy);
    end
  endtask

  task automatic test_reset_midrun;
    int busy_after = 0;
    stall_cfg = 3;
    id_ret = 32'hDEAD_0001;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      start = (n == 2);
    end
    start = 1'b0;
    checks++;
    if (a_read !== 1'b1 || a_addr !== 1'b1 || a_idv !== 32'hDEAD_0001) begin
      failures++; $display("FAIL rst_pre got=%b/%b/%h exp=1/1/dead0001", a_read, a_addr, a_idv);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_read, a_busy, a_done, a_addr} !== 4'b0) begin
      failures++; $display("FAIL rst_async got=%b exp=0", {a_read, a_busy, a_done, a_addr});
    end
    checks++;
    if ({a_idv, a_tsv} !== 64'd0 || b_busy !== 1'b0) begin
      failures++; $display("FAIL rst_values got=%h/%b exp=0/0", {a_idv, a_tsv}, b_busy);
    end
    #1 reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (a_busy || b_busy) busy_after++;
    end
    checks++;
    if (busy_after !== 0) begin
      failures++; $display("FAIL rst_after got=%0d exp=0", busy_after);
    end
    stall_cfg = 0;
    id_ret = 32'd0;
  endtask

  initial begin
    test_reset;
    test_rdv;
    test_match;
    test_ts_mismatch;
    test_stall;
    test_timeout;
    test_start_ignored;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
